// File: rtl/branch_predictor_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor_if
//  Description : Bundle between the pipeline and the branch direction
//                predictor. The fetch-side lookup (if_*), the EX-side
//                resolution (ex_*), and the predictor's results travel here.
//                master : pipeline side (drives PCs/opcode/outcomes)
//                slave  : predictor side (drives prediction, flush, stats)
//  Revision    : 1.0  initial release
// ============================================================================
interface branch_predictor_if #(
    parameter int PC_WIDTH   = 64,
    parameter int STAT_WIDTH = 32
);
    // Fetch-stage lookup
    logic [PC_WIDTH-1:0]   if_pc;
    logic [6:0]            if_opcode;
    logic                  predict_taken;
    // EX-stage resolution
    logic                  ex_valid;
    logic [PC_WIDTH-1:0]   ex_pc;
    logic                  ex_taken;
    logic                  ex_predicted;
    logic                  mispredict;
    // Statistics
    logic [STAT_WIDTH-1:0] branch_count;
    logic [STAT_WIDTH-1:0] mispredict_count;

    modport master (
        output if_pc, if_opcode, ex_valid, ex_pc, ex_taken, ex_predicted,
        input  predict_taken, mispredict, branch_count, mispredict_count
    );

    modport slave (
        input  if_pc, if_opcode, ex_valid, ex_pc, ex_taken, ex_predicted,
        output predict_taken, mispredict, branch_count, mispredict_count
    );
endinterface
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor
//  Description : Dynamic branch direction predictor. A table of 2-bit
//                saturating counters, indexed by PC[INDEX_BITS+1:2], gives
//                a zero-latency prediction for conditional branches in
//                fetch. Branches resolving in EX train the table, raise a
//                same-cycle mispredict flag, and bump saturating statistics.
//  Ports       : clk    - rising-edge clock
//                reset  - synchronous, active-high reset
//                bus    - branch_predictor_if.slave
//                         in : if_pc, if_opcode, ex_valid, ex_pc,
//                              ex_taken, ex_predicted
//                         out: predict_taken (comb), mispredict (comb),
//                              branch_count, mispredict_count (registered)
//  Revision    : 1.0  initial release
// ============================================================================
module branch_predictor #(
    parameter int INDEX_BITS = 4,
    parameter int PC_WIDTH   = 64,
    parameter int STAT_WIDTH = 32
) (
    input  wire                  clk,
    input  wire                  reset,
    branch_predictor_if.slave    bus
);

    localparam int                    c_ENTRIES   = 1 << INDEX_BITS;
    localparam logic [6:0]            c_OP_BRANCH = 7'b1100011;
    localparam logic [1:0]            c_CTR_INIT  = 2'b01;
    localparam logic [STAT_WIDTH-1:0] c_STAT_ONE  = {{(STAT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [STAT_WIDTH-1:0] c_STAT_MAX  = {STAT_WIDTH{1'b1}};

    logic [1:0]            r_table [0:c_ENTRIES-1];
    logic [STAT_WIDTH-1:0] r_branch_count;
    logic [STAT_WIDTH-1:0] r_mispredict_count;

    logic [INDEX_BITS-1:0] w_if_idx;
    logic [INDEX_BITS-1:0] w_ex_idx;
    logic [1:0]            w_ex_ctr;
    logic [1:0]            w_ex_ctr_next;
    logic                  w_mispredict;

    // Word-aligned index; upper PC bits are untagged so aliasing is allowed.
    assign w_if_idx = bus.if_pc[INDEX_BITS+1:2];
    assign w_ex_idx = bus.ex_pc[INDEX_BITS+1:2];

    // Prediction reads the registered table only, so a same-index update in
    // this cycle is not visible until the next one.
    assign bus.predict_taken = (bus.if_opcode == c_OP_BRANCH) && r_table[w_if_idx][1];

    assign w_mispredict   = bus.ex_valid && (bus.ex_taken != bus.ex_predicted);
    assign bus.mispredict = w_mispredict;

    assign w_ex_ctr = r_table[w_ex_idx];

    always_comb begin
        w_ex_ctr_next = w_ex_ctr;
        if (bus.ex_taken) begin
            if (w_ex_ctr != 2'b11) w_ex_ctr_next = w_ex_ctr + 2'b01;
        end else begin
            if (w_ex_ctr != 2'b00) w_ex_ctr_next = w_ex_ctr - 2'b01;
        end
    end

    // Reset wins over a coincident update, which is simply dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_table[i] <= c_CTR_INIT;
            end
        end else if (bus.ex_valid) begin
            r_table[w_ex_idx] <= w_ex_ctr_next;
        end
    end

    // Statistics stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            if (bus.ex_valid && (r_branch_count != c_STAT_MAX)) begin
                r_branch_count <= r_branch_count + c_STAT_ONE;
            end
            if (w_mispredict && (r_mispredict_count != c_STAT_MAX)) begin
                r_mispredict_count <= r_mispredict_count + c_STAT_ONE;
            end
        end
    end

    assign bus.branch_count     = r_branch_count;
    assign bus.mispredict_count = r_mispredict_count;

    // PC bits outside the index window take no part in the lookup.
    logic w_unused;
    assign w_unused = ^{bus.if_pc[PC_WIDTH-1:INDEX_BITS+2], bus.if_pc[1:0],
                        bus.ex_pc[PC_WIDTH-1:INDEX_BITS+2], bus.ex_pc[1:0]};

endmodule
`default_nettype wire
